// File: rtl/ntm_dot_pkg.sv
// Shared constants and types for the NTM dot-product datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   NTM_DATA_SIZE    - default operand/result width, matches accelerator system size
//   NTM_CONTROL_SIZE - default width of length/index counters
//   NTM_SATURATE     - default overflow policy (1 = clamp, 0 = wrap)
//   dot_state_t      - FSM encoding shared by the dot-product engine
package ntm_dot_pkg;

    localparam int NTM_DATA_SIZE    = 64;
    localparam int NTM_CONTROL_SIZE = 64;
    localparam bit NTM_SATURATE     = 1'b1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INPUT      = 2'd1,
        ACCUMULATE = 2'd2,
        ENDER      = 2'd3
    } dot_state_t;

endpackage : ntm_dot_pkg

// File: rtl/ntm_scalar_saturator.sv
// Narrows a 2*DATA_SIZE signed value to DATA_SIZE bits, clamping or wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   data_i     - 2*DATA_SIZE-bit signed two's complement value
//   data_o     - DATA_SIZE-bit result (clamped when SATURATE=1, low bits otherwise)
//   overflow_o - 1 when data_i does not fit the DATA_SIZE signed range (both modes)
module ntm_scalar_saturator
    import ntm_dot_pkg::*;
#(
    parameter int DATA_SIZE = NTM_DATA_SIZE,
    parameter bit SATURATE  = NTM_SATURATE
) (
    input  logic [2*DATA_SIZE-1:0] data_i,
    output logic [DATA_SIZE-1:0]   data_o,
    output logic                   overflow_o
);

    localparam logic [DATA_SIZE-1:0] MAX_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] MIN_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

    // The value fits in DATA_SIZE signed bits exactly when the upper
    // DATA_SIZE+1 bits are a pure sign extension (all zeros or all ones).
    logic [DATA_SIZE:0] top_bits;

    assign top_bits   = data_i[2*DATA_SIZE-1:DATA_SIZE-1];
    assign overflow_o = !((&top_bits) || !(|top_bits));

    always_comb begin
        data_o = data_i[DATA_SIZE-1:0];
        if (SATURATE && overflow_o) begin
            data_o = data_i[2*DATA_SIZE-1] ? MIN_NEG : MAX_POS;
        end
    end

endmodule : ntm_scalar_saturator

// File: rtl/ntm_vector_dot_product.sv
// Streaming signed dot product sum(A[i]*B[i]) over a runtime length n.
// Latency: 3 cycles per element when operands arrive the cycle after each request, +2 to READY.
// Backpressure: block paces itself with a one-cycle DATA_ENABLE request and waits indefinitely for both operands.
//
// Ports:
//   CLK, RST                        - clock, asynchronous active-low reset
//   START, LENGTH_IN                - begin a run of LENGTH_IN elements (sampled in IDLE only)
//   DATA_ENABLE                     - one-cycle request for the next (A,B) element pair
//   DATA_A_IN_ENABLE, DATA_A_IN     - A operand strobe and value
//   DATA_B_IN_ENABLE, DATA_B_IN     - B operand strobe and value
//   READY, DATA_OUT, OVERFLOW_OUT   - one-cycle result strobe; result/overflow held until next run ends
module ntm_vector_dot_product
    import ntm_dot_pkg::*;
#(
    parameter int DATA_SIZE    = NTM_DATA_SIZE,
    parameter int CONTROL_SIZE = NTM_CONTROL_SIZE,
    parameter bit SATURATE     = NTM_SATURATE
) (
    input  logic                    CLK,
    input  logic                    RST,

    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] LENGTH_IN,

    output logic                    DATA_ENABLE,
    input  logic                    DATA_A_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic                    DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,

    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    OVERFLOW_OUT
);

    localparam int                    ACC_W    = 2 * DATA_SIZE;
    localparam logic [CONTROL_SIZE-1:0] CTRL_ONE = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

    dot_state_t              state_q,   state_d;
    logic [CONTROL_SIZE-1:0] len_q,     len_d;
    logic [CONTROL_SIZE-1:0] idx_q,     idx_d;
    logic [ACC_W-1:0]        acc_q,     acc_d;
    logic [DATA_SIZE-1:0]    a_q,       a_d;
    logic [DATA_SIZE-1:0]    b_q,       b_d;
    logic                    a_vld_q,   a_vld_d;
    logic                    b_vld_q,   b_vld_d;
    logic                    ready_q,   ready_d;
    logic                    de_q,      de_d;
    logic [DATA_SIZE-1:0]    dout_q,    dout_d;
    logic                    ovf_q,     ovf_d;

    logic [ACC_W-1:0]        prod;
    logic [DATA_SIZE-1:0]    sat_dat;
    logic                    sat_ovf;

    // Sign-extend both operands to the accumulator width first: the low
    // ACC_W bits of that unsigned product equal the full signed product.
    assign prod = {{DATA_SIZE{a_q[DATA_SIZE-1]}}, a_q} *
                  {{DATA_SIZE{b_q[DATA_SIZE-1]}}, b_q};

    // The accumulator itself wraps modulo 2^ACC_W; only the final
    // narrowing to DATA_SIZE is checked for overflow.
    ntm_scalar_saturator #(
        .DATA_SIZE (DATA_SIZE),
        .SATURATE  (SATURATE)
    ) u_sat (
        .data_i     (acc_q),
        .data_o     (sat_dat),
        .overflow_o (sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        a_vld_d = a_vld_q;
        b_vld_d = b_vld_q;
        ready_d = 1'b0;
        de_d    = 1'b0;
        dout_d  = dout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    len_d   = LENGTH_IN;
                    idx_d   = '0;
                    acc_d   = '0;
                    a_vld_d = 1'b0;
                    b_vld_d = 1'b0;
                    if (LENGTH_IN == '0) begin
                        state_d = ENDER;
                    end else begin
                        de_d    = 1'b1;
                        state_d = INPUT;
                    end
                end
            end

            INPUT: begin
                // First strobe per operand wins; later strobes for an
                // already-captured operand are dropped.
                if (DATA_A_IN_ENABLE && !a_vld_q) begin
                    a_d     = DATA_A_IN;
                    a_vld_d = 1'b1;
                end
                if (DATA_B_IN_ENABLE && !b_vld_q) begin
                    b_d     = DATA_B_IN;
                    b_vld_d = 1'b1;
                end
                if (a_vld_d && b_vld_d) begin
                    state_d = ACCUMULATE;
                end
            end

            ACCUMULATE: begin
                acc_d   = acc_q + prod;
                a_vld_d = 1'b0;
                b_vld_d = 1'b0;
                if (idx_q == len_q - CTRL_ONE) begin
                    state_d = ENDER;
                end else begin
                    idx_d   = idx_q + CTRL_ONE;
                    de_d    = 1'b1;
                    state_d = INPUT;
                end
            end

            ENDER: begin
                dout_d  = sat_dat;
                ovf_d   = sat_ovf;
                ready_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            ready_q <= 1'b0;
            de_q    <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            ready_q <= ready_d;
            de_q    <= de_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign READY        = ready_q;
    assign DATA_ENABLE  = de_q;
    assign DATA_OUT     = dout_q;
    assign OVERFLOW_OUT = ovf_q;

endmodule : ntm_vector_dot_product

// File: tb/tb_ntm_vector_dot_product.sv
// Scoreboard bench for ntm_vector_dot_product: one saturating and one wrapping
// instance share stimulus; the driver queues expected results, the monitor
// pops and checks them on each READY.
module tb_ntm_vector_dot_product;

    localparam int DS = 8;
    localparam int CS = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic [CS-1:0] LENGTH_IN = '0;
    logic          a_en = 1'b0;
    logic          b_en = 1'b0;
    logic [DS-1:0] a_dat = '0;
    logic [DS-1:0] b_dat = '0;

    logic          rdy_s, de_s, ovf_s;
    logic [DS-1:0] dout_s;
    logic          rdy_w, de_w, ovf_w;
    logic [DS-1:0] dout_w;

    always #5 CLK = ~CLK;

    ntm_vector_dot_product #(.DATA_SIZE(DS), .CONTROL_SIZE(CS), .SATURATE(1'b1)) u_sat (
        .CLK(CLK), .RST(RST), .START(START), .READY(rdy_s), .LENGTH_IN(LENGTH_IN),
        .DATA_ENABLE(de_s), .DATA_A_IN_ENABLE(a_en), .DATA_A_IN(a_dat),
        .DATA_B_IN_ENABLE(b_en), .DATA_B_IN(b_dat),
        .DATA_OUT(dout_s), .OVERFLOW_OUT(ovf_s)
    );

    ntm_vector_dot_product #(.DATA_SIZE(DS), .CONTROL_SIZE(CS), .SATURATE(1'b0)) u_wrap (
        .CLK(CLK), .RST(RST), .START(START), .READY(rdy_w), .LENGTH_IN(LENGTH_IN),
        .DATA_ENABLE(de_w), .DATA_A_IN_ENABLE(a_en), .DATA_A_IN(a_dat),
        .DATA_B_IN_ENABLE(b_en), .DATA_B_IN(b_dat),
        .DATA_OUT(dout_w), .OVERFLOW_OUT(ovf_w)
    );

    typedef struct {
        int ds;   // expected saturating result
        int dw;   // expected wrapping result
        int os;   // expected overflow, saturating instance
        int ow;   // expected overflow, wrapping instance
        int n;    // expected DATA_ENABLE pulses in the run
        int cyc;  // expected cyc value when READY is seen, -1 = not checked
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    int   checks = 0;
    int   errors = 0;
    int   de_since = 0;
    bit   finished = 1'b0;
    exp_t e;

    task automatic cmp(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            cmp("reset_sat_ready", int'(rdy_s), 0);
            cmp("reset_sat_de", int'(de_s), 0);
            cmp("reset_sat_dout", int'(dout_s), 0);
            cmp("reset_sat_ovf", int'(ovf_s), 0);
            cmp("reset_wrap_dout", int'(dout_w), 0);
            cmp("reset_wrap_ovf", int'(ovf_w), 0);
            de_since = 0;
        end else begin
            if (de_s) de_since++;
            if (rdy_s && de_s) begin
                errors++;
                $display("FAIL ready_de_overlap: READY=1 and DATA_ENABLE=1 together at cyc %0d", cyc);
            end
            if (rdy_s) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: READY at cyc %0d with no result queued", cyc);
                end else begin
                    e = q.pop_front();
                    cmp("sat_dout", int'($signed(dout_s)), e.ds);
                    cmp("sat_ovf", int'(ovf_s), e.os);
                    cmp("wrap_ready_sync", int'(rdy_w), 1);
                    cmp("wrap_dout", int'($signed(dout_w)), e.dw);
                    cmp("wrap_ovf", int'(ovf_w), e.ow);
                    cmp("data_enable_count", de_since, e.n);
                    if (e.cyc >= 0) cmp("ready_cycle", cyc, e.cyc);
                end
                de_since = 0;
            end
        end
        if (done && !finished) begin
            finished = 1'b1;
            cmp("results_outstanding", q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
            $finish;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_de();
        for (int i = 0; i < 40 && !de_s; i++) @(negedge CLK);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !rdy_s; i++) @(negedge CLK);
    endtask

    // Operands presented the cycle after DATA_ENABLE. With busy set, a
    // START with a different length is also raised mid-run.
    task automatic drive_pair(input int a, input int b, input bit busy);
        wait_de();
        @(posedge CLK); #1;
        a_dat = a[DS-1:0];
        b_dat = b[DS-1:0];
        a_en  = 1'b1;
        b_en  = 1'b1;
        if (busy) begin
            START     = 1'b1;
            LENGTH_IN = 8'd7;
        end
        @(posedge CLK); #1;
        a_en  = 1'b0;
        b_en  = 1'b0;
        START = 1'b0;
    endtask

    task automatic push_exp(input int ds, input int dw, input int os, input int ow,
                            input int n, input bit chk_cyc);
        exp_t x;
        x.ds  = ds;
        x.dw  = dw;
        x.os  = os;
        x.ow  = ow;
        x.n   = n;
        // cyc is read one edge before START is sampled; READY lands 3n+2 later.
        x.cyc = chk_cyc ? (cyc + 3 * n + 2) : -1;
        q.push_back(x);
    endtask

    task automatic issue_start(input int n);
        LENGTH_IN = n[CS-1:0];
        START     = 1'b1;
        @(posedge CLK); #1;
        START     = 1'b0;
    endtask

    task automatic run3(input int n, input int a0, input int b0, input int a1, input int b1,
                        input int a2, input int b2, input int ds, input int dw,
                        input int os, input int ow, input bit busy);
        push_exp(ds, dw, os, ow, n, 1'b1);
        issue_start(n);
        if (n > 0) drive_pair(a0, b0, busy);
        if (n > 1) drive_pair(a1, b1, 1'b0);
        if (n > 2) drive_pair(a2, b2, 1'b0);
        wait_ready();
    endtask

    initial begin
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // nominal: 12 - 14 - 5 = -7, with an ignored START while busy
        run3(3,    3, 4,   -2, 7,   5, -1,    -7,   -7, 0, 0, 1'b1);
        // back-to-back from here on: each START goes up in the READY cycle
        run3(2,  100, 100, 100, 100, 0, 0,    127,  32, 1, 1, 1'b0);  // +20000
        run3(2, -100, 100, -100, 100, 0, 0,  -128, -32, 1, 1, 1'b0);  // -20000
        run3(1,  127, 1,    0, 0,    0, 0,    127, 127, 0, 0, 1'b0);  // top of range
        run3(2,  -64, 1,  -64, 1,    0, 0,   -128,-128, 0, 0, 1'b0);  // bottom of range
        run3(2,   64, 1,   64, 1,    0, 0,    127,-128, 1, 1, 1'b0);  // +128
        run3(2, -128, 1,   -1, 1,    0, 0,   -128, 127, 1, 1, 1'b0);  // -129
        run3(1, -128, -128, 0, 0,    0, 0,    127,   0, 1, 1, 1'b0);  // largest product
        run3(0,    0, 0,    0, 0,    0, 0,      0,   0, 0, 0, 1'b0);  // empty vector

        // handshake ordering: (6,2) then (-3,3) -> 3
        push_exp(3, 3, 0, 0, 2, 1'b0);
        issue_start(2);
        wait_de();
        @(posedge CLK); #1; b_en = 1'b1; b_dat = 8'd2;
        @(posedge CLK); #1; b_dat = 8'd9;                       // repeat B, must be dropped
        @(posedge CLK); #1; b_en = 1'b0; a_en = 1'b1; a_dat = 8'd6;
        @(posedge CLK); #1; a_dat = 8'd9;                       // repeat A after capture
        @(posedge CLK); #1; a_en = 1'b0;
        drive_pair(-3, 3, 1'b0);
        wait_ready();

        // reset in the middle of an n=4 run, then a fresh n=1 run
        @(negedge CLK);
        issue_start(4);
        wait_de();
        @(posedge CLK); #1; RST = 1'b0;
        @(posedge CLK); #1; RST = 1'b1;
        @(negedge CLK);
        run3(1, 5, 5, 0, 0, 0, 0, 25, 25, 0, 0, 1'b0);

        @(posedge CLK); #1;
        done = 1'b1;
        repeat (5) @(posedge CLK);
        $display("FAIL monitor_stalled: summary not reached");
        $fatal(1);
    end

endmodule : tb_ntm_vector_dot_product

// File: doc/ntm_vector_dot_product.md
Name: ntm_vector_dot_product

Overview:
Parametrised streaming dot-product engine for the NTM accelerator. It computes sum(A[i]*B[i]) over a runtime-selected vector length and serves the read/write-head similarity and addressing paths. The two operand streams arrive on independent handshakes, and element requests are paced by the block. Overflow can be handled by saturating or by wrapping, chosen at elaboration.

Parameters:
DATA_SIZE, 64, operand/result width, signed two's complement integer
CONTROL_SIZE, 64, width of length and index counters
SATURATE, 1, 1 = clamp result to DATA_SIZE signed range; 0 = wrap (keep low DATA_SIZE bits)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, asynchronous, active-low
START  in  1  begin operation; sampled only in IDLE
READY  out  1  one-cycle pulse: DATA_OUT/OVERFLOW_OUT valid
LENGTH_IN  in  CONTROL_SIZE  vector length n, latched on accepted START
DATA_ENABLE  out  1  one-cycle request for the next element pair
DATA_A_IN_ENABLE  in  1  DATA_A_IN valid this cycle
DATA_A_IN  in  DATA_SIZE  element A[i]
DATA_B_IN_ENABLE  in  1  DATA_B_IN valid this cycle
DATA_B_IN  in  DATA_SIZE  element B[i]
DATA_OUT  out  DATA_SIZE  dot-product result, held until next result
OVERFLOW_OUT  out  1  final sum did not fit DATA_SIZE signed; held with DATA_OUT

Behaviour:
- Reset (RST=0, any time, including mid-operation): state IDLE; READY, DATA_ENABLE, DATA_OUT, OVERFLOW_OUT, index, accumulator and operand-captured flags all cleared to 0. Any operation in progress is aborted.
- FSM states: IDLE, INPUT, ACCUMULATE, ENDER.
- IDLE, START=1:
  - latch LENGTH_IN, clear accumulator and index.
  - if n=0: go to ENDER (result 0, OVERFLOW_OUT 0).
  - else: DATA_ENABLE=1 for one cycle; go to INPUT.
- INPUT: DATA_ENABLE=0.
  - A is captured on the first DATA_A_IN_ENABLE; B on the first DATA_B_IN_ENABLE.
  - A and B may arrive in either order or in the same cycle.
  - A repeat enable for an already-captured operand is ignored (first value wins).
  - Once both flags are set, go to ACCUMULATE on the next edge.
- ACCUMULATE:
  - accumulator += signed full product A*B (2*DATA_SIZE bits).
  - Accumulator is 2*DATA_SIZE bits and wraps modulo 2^(2*DATA_SIZE); this is documented, not flagged.
  - Clear operand flags.
  - if index = n-1: go to ENDER. Else index+1, DATA_ENABLE=1 for one cycle, go to INPUT.
- ENDER:
  - SATURATE=1: DATA_OUT = accumulator clamped to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1].
  - SATURATE=0: DATA_OUT = low DATA_SIZE bits of the accumulator.
  - OVERFLOW_OUT = 1 iff the accumulator lies outside the DATA_SIZE signed range (either mode).
  - READY=1 for one cycle; return to IDLE.
- START outside IDLE is ignored. Operand enables outside INPUT are ignored.
- Latency: count the START-sampling edge as cycle 0. If operands always arrive the cycle after DATA_ENABLE:
  - DATA_ENABLE is high in cycles 1, 4, 7, …
  - READY is high in cycle 3n+2.
  - For n=0, READY is high in cycle 2.
- READY and DATA_ENABLE are never high in the same cycle.
- Back-to-back runs: START may be asserted in the cycle READY is high. It is sampled in IDLE on the following edge.

Decomposition:
- Shared package ntm_dot_pkg:
  - DATA_SIZE/CONTROL_SIZE defaults, matching the accelerator's system-size constants.
  - state enum typedef (IDLE, INPUT, ACCUMULATE, ENDER).
  - SATURATE default.
- Sub-module ntm_scalar_saturator: combinational clamp from 2*DATA_SIZE to DATA_SIZE, with an overflow flag output. It is reused by other NTM arithmetic blocks.

Test Plan:
- Nominal, DATA_SIZE=8, SATURATE=1, n=3, A=[3,-2,5], B=[4,7,-1], operands the cycle after each DATA_ENABLE -> DATA_OUT=-7 (0xF9), OVERFLOW_OUT=0, READY in cycle 11, exactly 3 DATA_ENABLE pulses.
- Overflow, DATA_SIZE=8, n=2, A=B=[100,100] -> SATURATE=1: DATA_OUT=127, OVERFLOW_OUT=1. SATURATE=0: DATA_OUT=32, OVERFLOW_OUT=1.
- Handshake ordering, n=2, elements (6,2) and (-3,3):
  - element 0: B arrives 2 cycles before A; A then re-asserted with 9 (ignored).
  - element 1: A and B arrive in the same cycle.
  - -> DATA_OUT=3, each element accumulated once.
- n=0 -> no DATA_ENABLE, READY in cycle 2, DATA_OUT=0, OVERFLOW_OUT=0. START asserted while busy in a nominal run -> ignored, result unchanged.
- Reset mid-operation: RST=0 for 1 cycle while in INPUT of a n=4 run -> all outputs 0 immediately (asynchronous). A new START with n=1, A=5, B=5 -> DATA_OUT=25, READY in cycle 5.
